i2c_target_regs: RTL and testbench

I2C target (slave) that answers the commands our `i2c` initiator core issues, emulating a small sensor register map such as the MMA7455's. It holds a 32×8 register file behind a 7-bit bus address and supports register-pointer writes, data writes and repeated-start reads. Local logic can load sensor values into the register file and receives a strobe for every byte the bus writes. It is used as an on-FPGA stand-in for the accelerometer and as a loopback target for initiator bring-up.

---
 rtl/i2c_target_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target emulating a 32x8 sensor register map (pointer write, data write, repeated-start read).
// Define I2C_TGT_AUTOINC_EN to advance the register pointer after every committed or ACKed data byte.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] ADDR = 7'h1D,
  parameter int         NREG = 32
) (
  input  logic       I2C_clk,
  input  logic       I2C_rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic       ld_en,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       wr_stb,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

`ifdef I2C_TGT_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P,
    S_WR, S_ACK_W, S_RD, S_MACK, S_IGNORE
  } stateType;

  stateType    r_state, w_nextState;
  logic [1:0]  r_sclSync, r_sdaSync;
  logic        r_sclPrev, r_sdaPrev;
  logic [7:0]  r_shift;
  logic [3:0]  r_bitCnt;
  logic [4:0]  r_ptr;
  logic        r_rw, r_sdaOe, r_busy, r_wrStb;
  logic [4:0]  r_wrAddr;
  logic [7:0]  r_wrData;
  logic [7:0]  r_regs [NREG];

  logic w_scl, w_sda, w_sclRise, w_sclFall, w_start, w_stop;
  logic w_bitsDone, w_addrMatch;
  logic [7:0] w_rdByte;
  logic w_shiftIn, w_loadRd, w_rdShift, w_commit, w_ptrLoad, w_ptrInc, w_addrDone;
  logic w_oeNext, w_busyNext;

  assign w_scl       = r_sclSync[1];
  assign w_sda       = r_sdaSync[1];
  assign w_sclRise   = w_scl & ~r_sclPrev;
  assign w_sclFall   = ~w_scl & r_sclPrev;
  assign w_start     = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign w_stop      = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
  assign w_bitsDone  = (r_bitCnt == 4'd8);
  assign w_addrMatch = (r_shift[7:1] == ADDR);
  assign w_rdByte    = r_regs[r_ptr];

  assign sda     = r_sdaOe ? 1'b0 : 1'bz;
  assign wr_stb  = r_wrStb;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign busy    = r_busy;

  // Two-flop synchronizers idle high, followed by one flop for edge detection.
  always_ff @(posedge I2C_clk) begin
    if (I2C_rst) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[0], scl};
      r_sdaSync <= {r_sdaSync[0], sda};
      r_sclPrev <= r_sclSync[1];
      r_sdaPrev <= r_sdaSync[1];
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (I2C_rst) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_start) begin
      w_nextState = S_ADDR;
    end else if (w_stop) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:  if (w_sclFall && w_bitsDone) w_nextState = w_addrMatch ? S_ACK_A : S_IGNORE;
        S_ACK_A: if (w_sclFall) w_nextState = r_rw ? S_RD : S_PTR;
        S_PTR:   if (w_sclFall && w_bitsDone) w_nextState = S_ACK_P;
        S_ACK_P: if (w_sclFall) w_nextState = S_WR;
        S_WR:    if (w_sclFall && w_bitsDone) w_nextState = S_ACK_W;
        S_ACK_W: if (w_sclFall) w_nextState = S_WR;
        S_RD:    if (w_sclFall && w_bitsDone) w_nextState = S_MACK;
        S_MACK: begin
          if (w_sclRise && w_sda)                      w_nextState = S_IGNORE;
          else if (w_sclFall && r_bitCnt == 4'd1)      w_nextState = S_RD;
        end
        default: w_nextState = r_state;
      endcase
    end
  end

  // Datapath controls; SDA only ever changes on a detected SCL fall.
  always_comb begin
    w_shiftIn  = 1'b0;
    w_loadRd   = 1'b0;
    w_rdShift  = 1'b0;
    w_commit   = 1'b0;
    w_ptrLoad  = 1'b0;
    w_ptrInc   = 1'b0;
    w_addrDone = 1'b0;
    w_oeNext   = r_sdaOe;
    w_busyNext = r_busy;
    if (w_start) begin
      w_oeNext = 1'b0;
    end else if (w_stop) begin
      w_oeNext   = 1'b0;
      w_busyNext = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          w_shiftIn = w_sclRise;
          if (w_sclFall && w_bitsDone) begin
            w_addrDone = 1'b1;
            w_oeNext   = w_addrMatch;
            w_busyNext = w_addrMatch;
          end
        end
        S_ACK_A: begin
          if (w_sclFall) begin
            w_loadRd = r_rw;
            w_oeNext = r_rw & ~w_rdByte[7];
          end
        end
        S_PTR: begin
          w_shiftIn = w_sclRise;
          if (w_sclFall && w_bitsDone) begin
            w_ptrLoad = 1'b1;
            w_oeNext  = 1'b1;
          end
        end
        S_WR: begin
          w_shiftIn = w_sclRise;
          if (w_sclFall && w_bitsDone) begin
            w_commit = 1'b1;
            w_ptrInc = AUTOINC;
            w_oeNext = 1'b1;
          end
        end
        S_ACK_P, S_ACK_W: if (w_sclFall) w_oeNext = 1'b0;
        S_RD: begin
          if (w_sclFall) begin
            if (w_bitsDone) begin
              w_oeNext = 1'b0;
            end else begin
              w_rdShift = 1'b1;
              w_oeNext  = ~r_shift[6];
            end
          end
        end
        S_MACK: begin
          if (w_sclRise) begin
            if (w_sda) w_busyNext = 1'b0;
            else       w_ptrInc   = AUTOINC;
          end else if (w_sclFall && r_bitCnt == 4'd1) begin
            w_loadRd = 1'b1;
            w_oeNext = ~w_rdByte[7];
          end
        end
        default: w_oeNext = 1'b0;
      endcase
    end
  end

  always_ff @(posedge I2C_clk) begin
    if (I2C_rst) begin
      r_shift  <= 8'h00;
      r_bitCnt <= 4'd0;
      r_ptr    <= 5'd0;
      r_rw     <= 1'b0;
      r_sdaOe  <= 1'b0;
      r_busy   <= 1'b0;
      r_wrStb  <= 1'b0;
      r_wrAddr <= 5'd0;
      r_wrData <= 8'h00;
    end else begin
      r_sdaOe <= w_oeNext;
      r_busy  <= w_busyNext;
      r_wrStb <= w_commit;
      if (w_start || (r_state != w_nextState)) r_bitCnt <= 4'd0;
      else if (w_sclRise)                       r_bitCnt <= r_bitCnt + 4'd1;
      if (w_shiftIn)      r_shift <= {r_shift[6:0], w_sda};
      else if (w_loadRd)  r_shift <= w_rdByte;
      else if (w_rdShift) r_shift <= {r_shift[6:0], 1'b0};
      if (w_addrDone) r_rw <= r_shift[0];
      if (w_ptrLoad)     r_ptr <= r_shift[4:0];
      else if (w_ptrInc) r_ptr <= r_ptr + 5'd1;
      if (w_commit) begin
        r_wrAddr <= r_ptr;
        r_wrData <= r_shift;
      end
    end
  end

  // A local load to the same index as a bus commit wins by being assigned last.
  always_ff @(posedge I2C_clk) begin
    if (I2C_rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_commit) r_regs[r_ptr] <= r_shift;
      if (ld_en)    r_regs[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bit-banged I2C initiator plus strobe and read-data scoreboards.
// Expectations follow I2C_TGT_AUTOINC_EN when the same define is given to the bench.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam int Q = 50;

  logic       I2C_clk = 1'b0;
  logic       I2C_rst;
  logic       scl;
  logic       masterLow;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       wr_stb;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  int assertCount = 0;
  int failCount   = 0;
  logic        dutDrove;
  logic [12:0] expQ[$];
  logic [12:0] obsQ[$];
  logic [7:0]  rdExpQ[$];

  assign sda = masterLow ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 I2C_clk = ~I2C_clk;

  i2c_target_regs dut (
    .I2C_clk (I2C_clk),
    .I2C_rst (I2C_rst),
    .scl     (scl),
    .sda     (sda),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  // Every strobed cycle lands in the observed queue; a stretched strobe shows up as an extra entry.
  always @(negedge I2C_clk) begin
    if (wr_stb === 1'b1) obsQ.push_back({wr_addr, wr_data});
    if (sda === 1'b0 && !masterLow) dutDrove = 1'b1;
  end

  task automatic clockBit(input logic b, output logic s);
    masterLow = ~b;
    #(Q); scl = 1'b1;
    #(Q); s = sda;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2cStart;
    masterLow = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); masterLow = 1'b1;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2cStop;
    masterLow = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); masterLow = 1'b0;
    #(2*Q);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      d[i] = s;
    end
    clockBit(nack, s);
  endtask

  task automatic setPtrAndRead(input logic [4:0] ptr);
    logic ack;
    i2cStart;
    writeByte(8'h3A, ack);
    writeByte({3'b000, ptr}, ack);
    i2cStart;
    writeByte(8'h3B, ack);
  endtask

  task automatic test_reset;
    assertCount++; if (wr_stb !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_wr_stb got %b want 0", wr_stb); end
    assertCount++; if (wr_addr !== 5'h0) begin failCount++; $display("[TB] FAIL reset_wr_addr got %h want 00", wr_addr); end
    assertCount++; if (wr_data !== 8'h0) begin failCount++; $display("[TB] FAIL reset_wr_data got %h want 00", wr_data); end
    assertCount++; if (busy !== 1'b0)    begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    assertCount++; if (sda !== 1'b1)     begin failCount++; $display("[TB] FAIL reset_sda got %b want 1", sda); end
  endtask

  task automatic test_write;
    logic [7:0] bytes [3];
    logic ack;
    logic [12:0] e, o;
    bytes = '{8'h3A, 8'h16, 8'h05};
    expQ.push_back({5'h16, 8'h05});
    i2cStart;
    for (int i = 0; i < 3; i++) begin
      writeByte(bytes[i], ack);
      assertCount++;
      if (ack !== 1'b0) begin failCount++; $display("[TB] FAIL write_ack%0d got %b want 0", i, ack); end
      if (i == 0) begin
        assertCount++;
        if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL write_busy_high got %b want 1", busy); end
      end
    end
    i2cStop;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL write_busy_low got %b want 0", busy); end
    assertCount++;
    if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL write_strobe_count got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertCount++;
      if (o !== e) begin failCount++; $display("[TB] FAIL write_strobe got %h want %h", o, e); end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_nack_address;
    logic ack;
    dutDrove = 1'b0;
    i2cStart;
    writeByte(8'h3C, ack);
    assertCount++; if (ack !== 1'b1) begin failCount++; $display("[TB] FAIL nack_ack got %b want 1", ack); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL nack_busy got %b want 0", busy); end
    i2cStop;
    assertCount++; if (dutDrove !== 1'b0) begin failCount++; $display("[TB] FAIL nack_sda_driven got %b want 0", dutDrove); end
    assertCount++; if (obsQ.size() != 0) begin failCount++; $display("[TB] FAIL nack_strobe_count got %0d want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_load_read;
    logic ack;
    logic [7:0] d, e;
    @(negedge I2C_clk);
    ld_en = 1'b1; ld_addr = 5'h06; ld_data = 8'h7F;
    @(negedge I2C_clk);
    ld_en = 1'b0;
    rdExpQ.push_back(8'h7F);
    i2cStart;
    writeByte(8'h3A, ack);
    writeByte(8'h06, ack);
    i2cStart;
    writeByte(8'h3B, ack);
    assertCount++; if (ack !== 1'b0) begin failCount++; $display("[TB] FAIL load_read_ack got %b want 0", ack); end
    readByte(1'b1, d);
    i2cStop;
    e = rdExpQ.pop_front();
    assertCount++; if (d !== e) begin failCount++; $display("[TB] FAIL load_read_data got %h want %h", d, e); end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL load_read_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic ack;
    logic [7:0] d, e;
    logic [12:0] eo, oo;
`ifdef I2C_TGT_AUTOINC_EN
    expQ.push_back({5'h1F, 8'hAA}); expQ.push_back({5'h00, 8'hBB});
    rdExpQ.push_back(8'hAA); rdExpQ.push_back(8'hBB);
`else
    expQ.push_back({5'h1F, 8'hAA}); expQ.push_back({5'h1F, 8'hBB});
    rdExpQ.push_back(8'hBB); rdExpQ.push_back(8'hBB);
`endif
    i2cStart;
    writeByte(8'h3A, ack);
    writeByte(8'h1F, ack);
    writeByte(8'hAA, ack);
    writeByte(8'hBB, ack);
    assertCount++; if (ack !== 1'b0) begin failCount++; $display("[TB] FAIL burst_last_ack got %b want 0", ack); end
    i2cStop;
    assertCount++;
    if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL burst_strobe_count got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      eo = expQ.pop_front(); oo = obsQ.pop_front();
      assertCount++;
      if (oo !== eo) begin failCount++; $display("[TB] FAIL burst_strobe got %h want %h", oo, eo); end
    end
    expQ.delete(); obsQ.delete();
    setPtrAndRead(5'h1F);
    for (int i = 0; i < 2; i++) begin
      readByte(i == 1, d);
      e = rdExpQ.pop_front();
      assertCount++;
      if (d !== e) begin failCount++; $display("[TB] FAIL burst_read%0d got %h want %h", i, d, e); end
    end
    i2cStop;
  endtask

  task automatic test_partial_stop;
    logic ack, s;
    logic [7:0] d, e;
    i2cStart;
    writeByte(8'h3A, ack);
    writeByte(8'h16, ack);
    for (int i = 0; i < 4; i++) clockBit(1'b1, s);
    i2cStop;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL partial_busy got %b want 0", busy); end
    assertCount++; if (obsQ.size() != 0) begin failCount++; $display("[TB] FAIL partial_strobe_count got %0d want 0", obsQ.size()); end
    obsQ.delete();
    rdExpQ.push_back(8'h05);
    setPtrAndRead(5'h16);
    readByte(1'b1, d);
    i2cStop;
    e = rdExpQ.pop_front();
    assertCount++; if (d !== e) begin failCount++; $display("[TB] FAIL partial_reg got %h want %h", d, e); end
  endtask

  task automatic test_reset_midread;
    logic ack, s;
    logic [7:0] d, e;
    logic [12:0] eo, oo;
    setPtrAndRead(5'h16);
    clockBit(1'b1, s);
    clockBit(1'b1, s);
    assertCount++; if (sda !== 1'b0) begin failCount++; $display("[TB] FAIL midread_driving got %b want 0", sda); end
    @(negedge I2C_clk); I2C_rst = 1'b1;
    @(negedge I2C_clk); I2C_rst = 1'b0;
    assertCount++; if (sda !== 1'b1)     begin failCount++; $display("[TB] FAIL midread_sda got %b want 1", sda); end
    assertCount++; if (busy !== 1'b0)    begin failCount++; $display("[TB] FAIL midread_busy got %b want 0", busy); end
    assertCount++; if (wr_addr !== 5'h0) begin failCount++; $display("[TB] FAIL midread_wr_addr got %h want 00", wr_addr); end
    assertCount++; if (wr_data !== 8'h0) begin failCount++; $display("[TB] FAIL midread_wr_data got %h want 00", wr_data); end
    i2cStop;
    expQ.push_back({5'h02, 8'h33});
    i2cStart;
    writeByte(8'h3A, ack);
    writeByte(8'h02, ack);
    writeByte(8'h33, ack);
    assertCount++; if (ack !== 1'b0) begin failCount++; $display("[TB] FAIL after_reset_ack got %b want 0", ack); end
    i2cStop;
    assertCount++;
    if (obsQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL after_reset_strobe_count got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      eo = expQ.pop_front(); oo = obsQ.pop_front();
      assertCount++;
      if (oo !== eo) begin failCount++; $display("[TB] FAIL after_reset_strobe got %h want %h", oo, eo); end
    end
    expQ.delete(); obsQ.delete();
    rdExpQ.push_back(8'h00);
    setPtrAndRead(5'h16);
    readByte(1'b1, d);
    i2cStop;
    e = rdExpQ.pop_front();
    assertCount++; if (d !== e) begin failCount++; $display("[TB] FAIL after_reset_reg got %h want %h", d, e); end
  endtask

  initial begin
    I2C_rst   = 1'b1;
    scl       = 1'b1;
    masterLow = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = 5'h0;
    ld_data   = 8'h0;
    dutDrove  = 1'b0;
    repeat (4) @(posedge I2C_clk);
    @(negedge I2C_clk);
    I2C_rst = 1'b0;
    repeat (4) @(negedge I2C_clk);
    $display("[TB] starting");
    test_reset;
    test_write;
    test_nack_address;
    test_load_read;
    test_back_to_back;
    test_partial_stop;
    test_reset_midread;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
